// File: rtl/mio_bus_if.sv
// mio_bus_if: core-side request/response bundle of the mio_bus controller.
// The core drives the master side. The bus controller implements the slave side.
interface mio_bus_if;
  logic        cpu_req;
  logic        mem_w;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [31:0] Data_out;
  logic        MIO_ready;

  modport master (
    output cpu_req, mem_w, Addr_in, Data_in,
    input  Data_out, MIO_ready
  );

  modport slave (
    input  cpu_req, mem_w, Addr_in, Data_in,
    output Data_out, MIO_ready
  );
endinterface

// File: rtl/mio_bus.sv
// mio_bus: memory/IO controller decoding core accesses to RAM, GPIO, seven-segment and timer.
// The interval timer, compare register and INT are built only when MIO_TIMER_EN is defined.
module mio_bus #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_if.slave          bus,
  output logic              INT,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led,
  output logic [31:0]       seg_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_RAM  = 3'd1,
    SEL_SEG  = 3'd2,
    SEL_GPIO = 3'd3,
    SEL_CNT  = 3'd4,
    SEL_CMP  = 3'd5
  } sel_t;

  localparam logic [29:0] SEG_WA  = 30'h3800_0000;
  localparam logic [29:0] GPIO_WA = 30'h3C00_0000;
  localparam logic [2:0]  WAIT_LD = 3'(WAIT_CYCLES);
`ifdef MIO_TIMER_EN
  localparam logic [29:0] CNT_WA  = 30'h3C00_0001;
  localparam logic [29:0] CMP_WA  = 30'h3C00_0002;
`endif

  // Word-level address decode; anything not matched is unmapped.
  function automatic sel_t decode(input logic [31:0] a);
    sel_t s;
    if ((a >> (RAM_AW + 2)) == 32'd0) begin
      s = SEL_RAM;
    end else if (a[31:2] == SEG_WA) begin
      s = SEL_SEG;
    end else if (a[31:2] == GPIO_WA) begin
      s = SEL_GPIO;
`ifdef MIO_TIMER_EN
    end else if (a[31:2] == CNT_WA) begin
      s = SEL_CNT;
    end else if (a[31:2] == CMP_WA) begin
      s = SEL_CMP;
`endif
    end else begin
      s = SEL_NONE;
    end
    return s;
  endfunction

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wr;
  logic [2:0]  r_wait;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_we;
  logic [15:0] r_led;
  logic [31:0] r_seg;
  sel_t        w_sel_in;
  sel_t        w_sel_r;
  logic [31:0] w_rd_data;

  assign w_sel_in = decode(bus.Addr_in);
  assign w_sel_r  = decode(r_addr);

`ifdef MIO_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_int;
  logic        w_cnt_wr;
  logic        w_cmp_wr;

  assign w_cnt_wr = (r_state == ST_RESP) && r_wr && (w_sel_r == SEL_CNT);
  assign w_cmp_wr = (r_state == ST_RESP) && r_wr && (w_sel_r == SEL_CMP);

  // Free-running counter; a compare write clears INT even if a match lands the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 32'd0;
      r_cmp   <= 32'd0;
      r_int   <= 1'b0;
    end else begin
      if (w_cnt_wr) begin
        r_count <= r_wdata;
      end else begin
        r_count <= r_count + 32'd1;
      end
      if (w_cmp_wr) begin
        r_cmp <= r_wdata;
        r_int <= 1'b0;
      end else if ((r_count == r_cmp) && (r_cmp != 32'd0)) begin
        r_int <= 1'b1;
      end else begin
        r_int <= r_int;
      end
    end
  end

  assign INT = r_int;
`else
  assign INT = 1'b0;
`endif

  // Read-data select for the access held in the address register.
  always_comb begin
    w_rd_data = 32'd0;
    case (w_sel_r)
      SEL_RAM:  w_rd_data = ram_dout;
      SEL_SEG:  w_rd_data = r_seg;
      SEL_GPIO: w_rd_data = {16'h0000, sw};
`ifdef MIO_TIMER_EN
      SEL_CNT:  w_rd_data = r_count;
      SEL_CMP:  w_rd_data = r_cmp;
`endif
      default:  w_rd_data = 32'd0;
    endcase
  end

  // Access FSM; ram_we is raised on entry to RESP so the RAM commits on the RESP edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wr    <= 1'b0;
      r_wait  <= 3'd0;
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
      r_we    <= 1'b0;
      r_led   <= 16'd0;
      r_seg   <= 32'd0;
    end else begin
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            r_addr  <= bus.Addr_in;
            r_wdata <= bus.Data_in;
            r_wr    <= bus.mem_w;
            if (!bus.mem_w && (w_sel_in == SEL_RAM) && (WAIT_LD != 3'd0)) begin
              r_wait  <= WAIT_LD;
              r_state <= ST_WAIT;
            end else begin
              r_we    <= bus.mem_w && (w_sel_in == SEL_RAM);
              r_state <= ST_RESP;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_wait <= 3'd1) begin
            r_state <= ST_RESP;
          end else begin
            r_wait  <= r_wait - 3'd1;
            r_state <= ST_WAIT;
          end
        end
        ST_RESP: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
          if (r_wr) begin
            case (w_sel_r)
              SEL_GPIO: r_led <= r_wdata[15:0];
              SEL_SEG:  r_seg <= r_wdata;
              default:  r_seg <= r_seg;
            endcase
          end else begin
            r_rdata <= w_rd_data;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Data_out  = r_rdata;
  assign bus.MIO_ready = r_ready;
  assign ram_addr      = r_addr[RAM_AW+1:2];
  assign ram_din       = r_wdata;
  assign ram_we        = r_we;
  assign led           = r_led;
  assign seg_data      = r_seg;

endmodule
